// File: rtl/cache_2way_wb.sv
// Two-way set-associative write-back data cache between the core load/store port and DDR2.
// Each set keeps one LRU bit; a dirty victim is written back before the requested line is filled.
module cache_2way_wb #(
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned SETS   = 512
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              available,
  output logic [ADDR_W-1:0] ddr2_addr,
  output logic [LINE_W-1:0] to_ddr2_data,
  output logic              ddr2_enable,
  output logic              ddr2_read,
  input  logic              ddr2_available,
  input  logic [LINE_W-1:0] ddr2_data
);

  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned WSEL_W = OFF_W - 2;

  typedef enum logic [1:0] {StIdle, StWb, StFill} state_e;

  // Storage
  logic [LINE_W-1:0] r_data  [2][SETS];
  logic [TAG_W-1:0]  r_tag   [2][SETS];
  logic [SETS-1:0]   r_valid [2];
  logic [SETS-1:0]   r_dirty [2];
  logic [SETS-1:0]   r_lru;

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_req_write;
  logic [31:0]       r_req_wdata;
  logic              r_victim;

  logic [31:0]       r_read_data, w_read_data_nxt;
  logic              r_available, w_available_nxt;
  logic [ADDR_W-1:0] r_ddr2_addr, w_ddr2_addr_nxt;
  logic [LINE_W-1:0] r_to_ddr2_data, w_to_ddr2_data_nxt;
  logic              r_ddr2_enable, w_ddr2_enable_nxt;
  logic              r_ddr2_read, w_ddr2_read_nxt;

  // Address fields of the incoming and latched request
  logic [IDX_W-1:0]  w_idx, w_ridx;
  logic [TAG_W-1:0]  w_tag, w_rtag;
  logic [WSEL_W-1:0] w_wsel, w_rwsel;

  assign w_idx   = addr[OFF_W+IDX_W-1:OFF_W];
  assign w_tag   = addr[ADDR_W-1:OFF_W+IDX_W];
  assign w_wsel  = addr[OFF_W-1:2];
  assign w_ridx  = r_req_addr[OFF_W+IDX_W-1:OFF_W];
  assign w_rtag  = r_req_addr[ADDR_W-1:OFF_W+IDX_W];
  assign w_rwsel = r_req_addr[OFF_W-1:2];

  logic [1:0]        w_hit;
  logic              w_hit_way;
  logic [LINE_W-1:0] w_hit_line;
  logic              w_victim;
  logic [LINE_W-1:0] w_vic_line;
  logic [TAG_W-1:0]  w_vic_tag;
  logic              w_vic_dirty;

  assign w_hit[0]    = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
  assign w_hit[1]    = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
  assign w_hit_way   = ~w_hit[0];
  assign w_hit_line  = r_data[w_hit_way][w_idx];
  // First invalid way wins; only a fully valid set consults LRU.
  assign w_victim    = !r_valid[0][w_idx] ? 1'b0 :
                       !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
  assign w_vic_line  = r_data[w_victim][w_idx];
  assign w_vic_tag   = r_tag[w_victim][w_idx];
  assign w_vic_dirty = r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];

  function automatic logic [31:0] get_word(input logic [LINE_W-1:0] line,
                                           input logic [WSEL_W-1:0] sel);
    return line[32*sel +: 32];
  endfunction

  function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                 input logic [WSEL_W-1:0] sel,
                                                 input logic [31:0]       word);
    logic [LINE_W-1:0] res;
    res = line;
    res[32*sel +: 32] = word;
    return res;
  endfunction

  // Array write port shared by store hits and fills
  logic              w_latch;
  logic              w_data_we;
  logic              w_tag_we;
  logic              w_meta_we;
  logic              w_meta_dirty;
  logic              w_lru_we;
  logic              w_lru_val;
  logic              w_wr_way;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [LINE_W-1:0] w_wr_line;

  always_comb begin
    w_state_nxt        = r_state;
    w_read_data_nxt    = r_read_data;
    w_available_nxt    = 1'b0;
    w_ddr2_addr_nxt    = r_ddr2_addr;
    w_to_ddr2_data_nxt = r_to_ddr2_data;
    w_ddr2_enable_nxt  = r_ddr2_enable;
    w_ddr2_read_nxt    = r_ddr2_read;
    w_latch            = 1'b0;
    w_data_we          = 1'b0;
    w_tag_we           = 1'b0;
    w_meta_we          = 1'b0;
    w_meta_dirty       = 1'b0;
    w_lru_we           = 1'b0;
    w_lru_val          = 1'b0;
    w_wr_way           = w_hit_way;
    w_wr_idx           = w_idx;
    w_wr_line          = put_word(w_hit_line, w_wsel, write_data);

    unique case (r_state)
      StIdle: begin
        if (enable) begin
          if (|w_hit) begin
            w_available_nxt = 1'b1;
            w_lru_we        = 1'b1;
            w_lru_val       = ~w_hit_way;
            if (write) begin
              w_data_we    = 1'b1;
              w_meta_we    = 1'b1;
              w_meta_dirty = 1'b1;
            end else begin
              w_read_data_nxt = get_word(w_hit_line, w_wsel);
            end
          end else begin
            w_latch           = 1'b1;
            w_ddr2_enable_nxt = 1'b1;
            if (w_vic_dirty) begin
              w_ddr2_addr_nxt    = {w_vic_tag, w_idx, {OFF_W{1'b0}}};
              w_to_ddr2_data_nxt = w_vic_line;
              w_ddr2_read_nxt    = 1'b0;
              w_state_nxt        = StWb;
            end else begin
              w_ddr2_addr_nxt = {w_tag, w_idx, {OFF_W{1'b0}}};
              w_ddr2_read_nxt = 1'b1;
              w_state_nxt     = StFill;
            end
          end
        end
      end

      StWb: begin
        if (ddr2_available) begin
          w_ddr2_addr_nxt = {w_rtag, w_ridx, {OFF_W{1'b0}}};
          w_ddr2_read_nxt = 1'b1;
          w_state_nxt     = StFill;
        end
      end

      StFill: begin
        if (ddr2_available) begin
          w_wr_way          = r_victim;
          w_wr_idx          = w_ridx;
          w_wr_line         = r_req_write ? put_word(ddr2_data, w_rwsel, r_req_wdata) : ddr2_data;
          w_data_we         = 1'b1;
          w_tag_we          = 1'b1;
          w_meta_we         = 1'b1;
          w_meta_dirty      = r_req_write;
          w_lru_we          = 1'b1;
          w_lru_val         = ~r_victim;
          w_wr_idx          = w_ridx;
          w_available_nxt   = 1'b1;
          w_ddr2_enable_nxt = 1'b0;
          w_state_nxt       = StIdle;
          if (!r_req_write) w_read_data_nxt = get_word(ddr2_data, w_rwsel);
        end
      end

      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= StIdle;
      r_read_data    <= '0;
      r_available    <= 1'b0;
      r_ddr2_addr    <= '0;
      r_to_ddr2_data <= '0;
      r_ddr2_enable  <= 1'b0;
      r_ddr2_read    <= 1'b0;
      r_req_addr     <= '0;
      r_req_write    <= 1'b0;
      r_req_wdata    <= '0;
      r_victim       <= 1'b0;
      r_valid[0]     <= '0;
      r_valid[1]     <= '0;
      r_dirty[0]     <= '0;
      r_dirty[1]     <= '0;
      r_lru          <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_read_data    <= w_read_data_nxt;
      r_available    <= w_available_nxt;
      r_ddr2_addr    <= w_ddr2_addr_nxt;
      r_to_ddr2_data <= w_to_ddr2_data_nxt;
      r_ddr2_enable  <= w_ddr2_enable_nxt;
      r_ddr2_read    <= w_ddr2_read_nxt;
      if (w_latch) begin
        r_req_addr  <= addr;
        r_req_write <= write;
        r_req_wdata <= write_data;
        r_victim    <= w_victim;
      end
      if (w_meta_we) begin
        r_valid[w_wr_way][w_wr_idx] <= 1'b1;
        r_dirty[w_wr_way][w_wr_idx] <= w_meta_dirty;
      end
      if (w_lru_we) r_lru[w_wr_idx] <= w_lru_val;
    end
  end

  // Line and tag storage carries no reset; valid bits guard it.
  always_ff @(posedge clk) begin
    if (w_data_we) r_data[w_wr_way][w_wr_idx] <= w_wr_line;
    if (w_tag_we)  r_tag[w_wr_way][w_wr_idx]  <= w_rtag;
  end

  assign read_data    = r_read_data;
  assign available    = r_available;
  assign ddr2_addr    = r_ddr2_addr;
  assign to_ddr2_data = r_to_ddr2_data;
  assign ddr2_enable  = r_ddr2_enable;
  assign ddr2_read    = r_ddr2_read;

  logic w_unused;
  assign w_unused = ^{addr[1:0], r_req_addr[1:0]};

endmodule

// File: tb/tb_cache_2way_wb.sv
// Directed bench for cache_2way_wb: table of load/store vectors with a scripted DDR2 responder,
// plus hand sequences for a long fill wait with ignored core inputs and reset mid-fill.
module tb_cache_2way_wb;

  logic         clk;
  logic         rstn;
  logic         enable;
  logic         write;
  logic [26:0]  addr;
  logic [31:0]  write_data;
  logic [31:0]  read_data;
  logic         available;
  logic [26:0]  ddr2_addr;
  logic [127:0] to_ddr2_data;
  logic         ddr2_enable;
  logic         ddr2_read;
  logic         ddr2_available;
  logic [127:0] ddr2_data;

  cache_2way_wb #(.ADDR_W(27), .LINE_W(128), .SETS(512)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .enable         (enable),
    .write          (write),
    .addr           (addr),
    .write_data     (write_data),
    .read_data      (read_data),
    .available      (available),
    .ddr2_addr      (ddr2_addr),
    .to_ddr2_data   (to_ddr2_data),
    .ddr2_enable    (ddr2_enable),
    .ddr2_read      (ddr2_read),
    .ddr2_available (ddr2_available),
    .ddr2_data      (ddr2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         w;
    logic [26:0]  a;
    logic [31:0]  wd;
    logic [127:0] fill;
    int           dly;
    logic         exp_hit;
    logic [31:0]  exp_rd;
    logic         exp_wb;
    logic [26:0]  exp_wb_addr;
    logic [31:0]  exp_wb_w0;
    logic [26:0]  exp_fill_addr;
  } vec_t;

  typedef struct {
    logic        hit;
    logic        en0;
    logic [31:0] rd;
    logic        wb;
    logic [26:0] wba;
    logic [31:0] wbw0;
    logic [26:0] fa;
    logic        frd;
    logic        fav;
    logic        fen;
    logic        stable;
  } res_t;

  function automatic vec_t mk(input logic w, input logic [26:0] a, input logic [31:0] wd,
                              input logic [127:0] fill, input int dly, input logic exp_hit,
                              input logic [31:0] exp_rd, input logic exp_wb,
                              input logic [26:0] exp_wb_addr, input logic [31:0] exp_wb_w0,
                              input logic [26:0] exp_fill_addr);
    vec_t v;
    v.w = w; v.a = a; v.wd = wd; v.fill = fill; v.dly = dly; v.exp_hit = exp_hit;
    v.exp_rd = exp_rd; v.exp_wb = exp_wb; v.exp_wb_addr = exp_wb_addr;
    v.exp_wb_w0 = exp_wb_w0; v.exp_fill_addr = exp_fill_addr;
    return v;
  endfunction

  // One core access; on a miss, acknowledges write-back at once and the fill after v.dly cycles.
  task automatic access(input vec_t v, output res_t r);
    r = '{default: '0};
    r.stable = 1'b1;
    @(negedge clk);
    enable = 1'b1; write = v.w; addr = v.a; write_data = v.wd;
    @(posedge clk); #1;
    enable = 1'b0;
    r.en0 = ddr2_enable;
    r.hit = available;
    r.rd  = read_data;
    if (!r.hit) begin
      if (ddr2_enable && !ddr2_read) begin
        r.wb   = 1'b1;
        r.wba  = ddr2_addr;
        r.wbw0 = to_ddr2_data[31:0];
        ddr2_available = 1'b1;
        @(posedge clk); #1;
        ddr2_available = 1'b0;
      end
      r.fa  = ddr2_addr;
      r.frd = ddr2_read;
      for (int i = 0; i < v.dly; i++) begin
        @(posedge clk); #1;
        if (ddr2_addr !== r.fa || ddr2_read !== r.frd || ddr2_enable !== 1'b1 ||
            available !== 1'b0) r.stable = 1'b0;
      end
      ddr2_data = v.fill;
      ddr2_available = 1'b1;
      @(posedge clk); #1;
      ddr2_available = 1'b0;
      r.fav = available;
      r.fen = ddr2_enable;
      r.rd  = read_data;
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    res_t r;
    access(v, r);
    if (v.exp_hit) begin
      chk({tag, "_hit"}, r.hit, 1'b1);
      chk({tag, "_no_ddr"}, r.en0, 1'b0);
      if (!v.w) chk({tag, "_rdata"}, r.rd, v.exp_rd);
    end else begin
      chk({tag, "_miss"}, r.hit, 1'b0);
      chk({tag, "_wb"}, r.wb, v.exp_wb);
      if (v.exp_wb) begin
        chk({tag, "_wb_addr"}, r.wba, v.exp_wb_addr);
        chk({tag, "_wb_word0"}, r.wbw0, v.exp_wb_w0);
      end
      chk({tag, "_fill_addr"}, r.fa, v.exp_fill_addr);
      chk({tag, "_fill_read"}, r.frd, 1'b1);
      chk({tag, "_fill_stable"}, r.stable, 1'b1);
      chk({tag, "_avail"}, r.fav, 1'b1);
      chk({tag, "_en_drop"}, r.fen, 1'b0);
      if (!v.w) chk({tag, "_rdata"}, r.rd, v.exp_rd);
    end
  endtask

  localparam logic [127:0] LineA = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
  localparam logic [127:0] LineB = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] LineC = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
  localparam logic [127:0] LineO = {4{32'h11111111}};

  vec_t vecs[12];

  initial begin
    vecs[0]  = mk(0, 27'h0000014, 0, LineA, 0, 0, 32'hBBBBBBBB, 0, 0, 0, 27'h0000010);
    vecs[1]  = mk(0, 27'h0000018, 0, '0,    0, 1, 32'hCCCCCCCC, 0, 0, 0, 0);
    vecs[2]  = mk(0, 27'h0002010, 0, LineB, 3, 0, 32'h11111111, 0, 0, 0, 27'h0002010);
    vecs[3]  = mk(0, 27'h000001C, 0, '0,    0, 1, 32'hDDDDDDDD, 0, 0, 0, 0);
    vecs[4]  = mk(0, 27'h0002014, 0, '0,    0, 1, 32'h22222222, 0, 0, 0, 0);
    vecs[5]  = mk(1, 27'h0000010, 32'h12345678, '0, 0, 1, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 27'h0002010, 0, '0,    0, 1, 32'h11111111, 0, 0, 0, 0);
    vecs[7]  = mk(0, 27'h0004010, 0, LineC, 1, 0, 32'hC0C0C0C0, 1, 27'h0000010, 32'h12345678,
                  27'h0004010);
    vecs[8]  = mk(1, 27'h0006018, 32'hCAFEF00D, LineO, 0, 0, 0, 0, 0, 0, 27'h0006010);
    vecs[9]  = mk(0, 27'h0006018, 0, '0,    0, 1, 32'hCAFEF00D, 0, 0, 0, 0);
    vecs[10] = mk(0, 27'h000601C, 0, '0,    0, 1, 32'h11111111, 0, 0, 0, 0);
    vecs[11] = mk(0, 27'h0004014, 0, '0,    0, 1, 32'hC1C1C1C1, 0, 0, 0, 0);

    rstn = 1'b0; enable = 1'b0; write = 1'b0; addr = '0; write_data = '0;
    ddr2_available = 1'b0; ddr2_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read_data", read_data, '0);
    chk("rst_available", available, '0);
    chk("rst_ddr2_addr", ddr2_addr, '0);
    chk("rst_to_ddr2_data", to_ddr2_data, '0);
    chk("rst_ddr2_enable", ddr2_enable, '0);
    chk("rst_ddr2_read", ddr2_read, '0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 12; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Long fill wait while the core wiggles enable/addr; those inputs must be ignored.
    begin
      logic [26:0] sa;
      logic        sr;
      logic        ok;
      ok = 1'b1;
      @(negedge clk);
      enable = 1'b1; write = 1'b0; addr = 27'h0000100;
      @(posedge clk); #1;
      chk("dly_en", ddr2_enable, 1'b1);
      chk("dly_addr", ddr2_addr, 27'h0000100);
      sa = ddr2_addr; sr = ddr2_read;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        enable = i[0];
        write  = i[1];
        addr   = i[0] ? 27'h0006018 : 27'h0004010;
        @(posedge clk); #1;
        if (ddr2_addr !== sa || ddr2_read !== sr || ddr2_enable !== 1'b1 || available !== 1'b0)
          ok = 1'b0;
      end
      chk("dly_stable", ok, 1'b1);
      enable = 1'b0; write = 1'b0; addr = 27'h0000100;
      ddr2_data = LineA; ddr2_available = 1'b1;
      @(posedge clk); #1;
      ddr2_available = 1'b0;
      chk("dly_avail", available, 1'b1);
      chk("dly_rdata", read_data, 32'hAAAAAAAA);
      chk("dly_en_drop", ddr2_enable, 1'b0);
      run_vec("dly_hit", mk(0, 27'h0000104, 0, '0, 0, 1, 32'hBBBBBBBB, 0, 0, 0, 0));
      run_vec("dly_tbl_hit", mk(0, 27'h0006018, 0, '0, 0, 1, 32'hCAFEF00D, 0, 0, 0, 0));
    end

    // Reset in the middle of a fill.
    @(negedge clk);
    enable = 1'b1; write = 1'b0; addr = 27'h0000200;
    @(posedge clk); #1;
    enable = 1'b0;
    chk("rstf_en_up", ddr2_enable, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rstf_en_drop", ddr2_enable, 1'b0);
    chk("rstf_avail", available, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    run_vec("rstf_reload", mk(0, 27'h0000104, 0, LineB, 0, 0, 32'h22222222, 0, 0, 0,
                              27'h0000100));
    run_vec("rstf_again", mk(0, 27'h0000208, 0, LineC, 2, 0, 32'hC2C2C2C2, 0, 0, 0,
                             27'h0000200));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
